free_list_ckpt_fifo: RTL and testbench

//   Circular free list of physical register tags for the rename stage. Hands out one

---
 rtl/free_list_ckpt_fifo.sv | 85 ++++++++
 tb/tb_free_list_ckpt_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_ckpt_fifo.sv
// Circular free list of physical register tags with zero-latency allocation,
// one release per cycle and head-pointer checkpoints for mispredict recovery.
module free_list_ckpt_fifo #(
  parameter  int WIDTH      = 6,
  parameter  int DEPTH      = 32,
  parameter  int INIT_BASE  = 32,
  parameter  int INIT_COUNT = 32,
  parameter  int NUM_CKPT   = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = AW + 1,
  localparam int CW         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [WIDTH-1:0] alloc_tag,
  input  logic             rel_en,
  input  logic [WIDTH-1:0] rel_tag,
  input  logic             ckpt_en,
  input  logic [CW-1:0]    ckpt_id,
  input  logic             restore_en,
  input  logic [CW-1:0]    restore_id,
  output logic [PW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr_next;
  logic [PW-1:0]       ckpt_slot [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_valid;
  logic                restore_ok;
  logic                rel_ok;

  always_comb begin
    count       = wr_ptr - rd_ptr;
    empty       = (count == '0);
    full        = (count == PW'(DEPTH));
    alloc_gnt   = alloc_req & ~empty & ~restore_en;
    alloc_tag   = mem[rd_ptr[AW-1:0]];
    // Head after this cycle's grant; this is what a checkpoint captures.
    rd_ptr_next = rd_ptr + PW'(alloc_gnt);
    restore_ok  = restore_en & ckpt_valid[restore_id];
    rel_ok      = rel_en & ~full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < INIT_COUNT) ? WIDTH'(INIT_BASE + i) : '0;
      end
    end else if (rel_ok) begin
      mem[wr_ptr[AW-1:0]] <= rel_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= PW'(INIT_COUNT);
      ckpt_valid <= '0;
      err        <= 1'b0;
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        ckpt_slot[i] <= '0;
      end
    end else begin
      rd_ptr <= restore_ok ? ckpt_slot[restore_id] : rd_ptr_next;
      if (rel_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (ckpt_en && !restore_en) begin
        ckpt_slot[ckpt_id]  <= rd_ptr_next;
        ckpt_valid[ckpt_id] <= 1'b1;
      end
      if ((rel_en && full) || (restore_en && !ckpt_valid[restore_id])) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list_ckpt_fifo.sv
// Bench for free_list_ckpt_fifo: directed scenarios plus randomized traffic
// checked against a ring-of-tags model using unbounded head/tail positions.
module tb_free_list_ckpt_fifo;
  localparam int WIDTH      = 6;
  localparam int DEPTH      = 32;
  localparam int INIT_BASE  = 32;
  localparam int INIT_COUNT = 32;
  localparam int NUM_CKPT   = 4;

  logic       clk = 1'b0;
  logic       rst, alloc_req, alloc_gnt, rel_en, ckpt_en, restore_en;
  logic       empty, full, err;
  logic [5:0] alloc_tag, rel_tag, count;
  logic [1:0] ckpt_id, restore_id;

  int total = 0;
  int bad   = 0;

  // Reference model: positions grow without bound, tags live at pos % DEPTH.
  int         head, tail;
  logic [5:0] ring [DEPTH];
  int         ck   [NUM_CKPT];
  bit         ckv  [NUM_CKPT];
  bit         m_err;

  always #5 clk = ~clk;

  free_list_ckpt_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_BASE(INIT_BASE),
    .INIT_COUNT(INIT_COUNT), .NUM_CKPT(NUM_CKPT)
  ) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .rel_en(rel_en), .rel_tag(rel_tag),
    .ckpt_en(ckpt_en), .ckpt_id(ckpt_id), .restore_en(restore_en),
    .restore_id(restore_id), .count(count), .empty(empty), .full(full), .err(err)
  );

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ring[i] = (i < INIT_COUNT) ? 6'(INIT_BASE + i) : 6'd0;
    for (int i = 0; i < NUM_CKPT; i++) begin ck[i] = 0; ckv[i] = 1'b0; end
    head = 0; tail = INIT_COUNT; m_err = 1'b0;
  endfunction

  function automatic int m_count();
    return tail - head;
  endfunction

  function automatic bit m_gnt();
    return alloc_req && (m_count() > 0) && !restore_en;
  endfunction

  function automatic void model_update();
    bit was_full;
    int hn;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (m_count() == DEPTH);
    hn = head + (m_gnt() ? 1 : 0);
    if (ckpt_en && !restore_en) begin ck[ckpt_id] = hn; ckv[ckpt_id] = 1'b1; end
    if (restore_en) begin
      if (ckv[restore_id]) head = ck[restore_id];
      else m_err = 1'b1;
    end else begin
      head = hn;
    end
    if (rel_en) begin
      if (!was_full) begin ring[tail % DEPTH] = rel_tag; tail++; end
      else m_err = 1'b1;
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alloc_req = 0; rel_en = 0; rel_tag = '0; ckpt_en = 0; ckpt_id = '0;
    restore_en = 0; restore_id = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1; alloc_req = 1; rel_en = 1; rel_tag = 6'd9;
    tick(); tick();
    rst = 0;
    set_idle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (count !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d exp=32", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL reset_full got=%0b exp=1", full); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%0b exp=0", empty); end
    total++; if (alloc_tag !== 6'd32) begin bad++; $display("FAIL reset_tag got=%0d exp=32", alloc_tag); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
  endtask

  task automatic test_drain();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 6'(32 + i)) begin
        bad++; $display("FAIL drain_tag got=%0d/%0b exp=%0d/1", alloc_tag, alloc_gnt, 32 + i);
      end
      tick();
    end
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL drain_gnt got=%0b exp=0", alloc_gnt); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    rel_en = 1; rel_tag = 6'd40;
    #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL no_bypass got=%0b exp=0", alloc_gnt); end
    tick();
    set_idle();
    #1;
    total++; if (alloc_tag !== 6'd40) begin bad++; $display("FAIL refill_tag got=%0d exp=40", alloc_tag); end
    total++; if (count !== 6'd1) begin bad++; $display("FAIL refill_count got=%0d exp=1", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_req = 1;
    repeat (20) tick();
    alloc_req = 0;
    rel_en = 1;
    for (int i = 1; i <= 20; i++) begin
      rel_tag = 6'(i);
      #1;
      total++; if (count !== 6'(11 + i)) begin bad++; $display("FAIL wrap_rel_count got=%0d exp=%0d", count, 11 + i); end
      tick();
    end
    rel_en = 0;
    #1;
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%0d/%0b exp=32/1", count, full); end
    alloc_req = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (alloc_tag !== 6'((i < 12) ? 52 + i : i - 11) || count !== 6'(32 - i)) begin
        bad++; $display("FAIL wrap_order got=%0d/%0d exp=%0d/%0d", alloc_tag, count,
                        (i < 12) ? 52 + i : i - 11, 32 - i);
      end
      tick();
    end
    alloc_req = 0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    alloc_req = 1;
    tick(); tick();
    ckpt_en = 1; ckpt_id = 2'd2;
    #1;
    total++; if (alloc_tag !== 6'd34) begin bad++; $display("FAIL ckpt_cycle_tag got=%0d exp=34", alloc_tag); end
    tick();
    ckpt_en = 0;
    tick(); tick(); tick();
    #1;
    total++; if (count !== 6'd26) begin bad++; $display("FAIL pre_restore_count got=%0d exp=26", count); end
    restore_en = 1; restore_id = 2'd2;
    #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL restore_gnt got=%0b exp=0", alloc_gnt); end
    tick();
    set_idle();
    #1;
    total++; if (alloc_tag !== 6'd35) begin bad++; $display("FAIL restore_tag got=%0d exp=35", alloc_tag); end
    total++; if (count !== 6'd29) begin bad++; $display("FAIL restore_count got=%0d exp=29", count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL restore_err got=%0b exp=0", err); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    alloc_req = 1;
    tick();
    ckpt_en = 1; ckpt_id = 2'd1;
    tick();
    ckpt_en = 0;
    tick(); tick(); tick();
    alloc_req = 0;
    restore_en = 1; restore_id = 2'd1; rel_en = 1; rel_tag = 6'd7;
    tick();
    set_idle();
    #1;
    total++; if (count !== 6'd31) begin bad++; $display("FAIL restore_rel_count got=%0d exp=31", count); end
    total++; if (alloc_tag !== 6'd34) begin bad++; $display("FAIL restore_rel_tag got=%0d exp=34", alloc_tag); end
    alloc_req = 1;
    tick(); tick();
    alloc_req = 0;
    restore_en = 1; restore_id = 2'd1; ckpt_en = 1; ckpt_id = 2'd1;
    tick();
    set_idle();
    alloc_req = 1;
    tick(); tick();
    alloc_req = 0;
    restore_en = 1; restore_id = 2'd1;
    tick();
    set_idle();
    #1;
    total++; if (alloc_tag !== 6'd34) begin bad++; $display("FAIL ckpt_ignored_tag got=%0d exp=34", alloc_tag); end
    total++; if (count !== 6'd31) begin bad++; $display("FAIL ckpt_ignored_count got=%0d exp=31", count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL simul_err got=%0b exp=0", err); end
  endtask

  task automatic test_errors();
    do_reset();
    rel_en = 1; rel_tag = 6'd5;
    tick();
    set_idle();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL overflow_err got=%0b exp=1", err); end
    total++; if (count !== 6'd32) begin bad++; $display("FAIL overflow_count got=%0d exp=32", count); end
    total++; if (alloc_tag !== 6'd32) begin bad++; $display("FAIL overflow_tag got=%0d exp=32", alloc_tag); end
    do_reset();
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear1 got=%0b exp=0", err); end
    alloc_req = 1;
    tick(); tick();
    restore_en = 1; restore_id = 2'd0;
    #1;
    total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL bad_restore_gnt got=%0b exp=0", alloc_gnt); end
    tick();
    set_idle();
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_restore_err got=%0b exp=1", err); end
    total++; if (alloc_tag !== 6'd34 || count !== 6'd30) begin
      bad++; $display("FAIL bad_restore_ptr got=%0d/%0d exp=34/30", alloc_tag, count);
    end
    do_reset();
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear2 got=%0b exp=0", err); end
  endtask

  task automatic test_random();
    int tn, span;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 399) == 0);
      alloc_req  = ($urandom_range(0, 99) < 55);
      rel_en     = ($urandom_range(0, 99) < 45);
      rel_tag    = 6'($urandom);
      ckpt_en    = ($urandom_range(0, 99) < 15);
      ckpt_id    = 2'($urandom);
      restore_en = ($urandom_range(0, 99) < 8);
      restore_id = 2'($urandom);
      if (restore_en && ckv[restore_id]) begin
        tn   = tail + ((rel_en && m_count() != DEPTH) ? 1 : 0);
        span = tn - ck[restore_id];
        if (span > DEPTH || span < 0) restore_en = 0;
      end
      #1;
      total++; if (count !== 6'(m_count())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, m_count()); end
      total++; if (empty !== (m_count() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%0b exp=%0b", n, empty, m_count() == 0); end
      total++; if (full !== (m_count() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got=%0b exp=%0b", n, full, m_count() == DEPTH); end
      total++; if (alloc_gnt !== m_gnt()) begin bad++; $display("FAIL rnd_gnt n=%0d got=%0b exp=%0b", n, alloc_gnt, m_gnt()); end
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, err, m_err); end
      if (m_count() > 0) begin
        total++;
        if (alloc_tag !== ring[head % DEPTH]) begin
          bad++; $display("FAIL rnd_tag n=%0d got=%0d exp=%0d", n, alloc_tag, ring[head % DEPTH]);
        end
      end
      tick();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_drain();
    test_wrap();
    test_ckpt_restore();
    test_simultaneous();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
